// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and defaults for the SDRAM arbiter.
//   state_e : arbiter FSM states (IDLE, BUSY, GAP)
//   op_e    : latched command kind (OP_READ, OP_WRITE)
//   ADDR_W_DEF / DATA_W_DEF : default SDRAM word address / data widths
package sdram_arb_pkg;

    localparam int ADDR_W_DEF = 23;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search.
//   i_pending : request vector, one bit per requester
//   i_ptr     : index of the most recently served requester
//   o_valid   : at least one requester is pending
//   o_onehot  : winner, one-hot (first pending bit from i_ptr+1 upward, wrapping)
//   o_idx     : winner as a binary index
module rr_picker #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_pending,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [NREQ-1:0]  o_onehot,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every output gets a default before the loop, so no path leaves
    // a value held and no latch is inferred.
    always_comb begin
        found    = 1'b0;
        o_onehot = '0;
        o_idx    = '0;
        cand     = '0;
        // Offset i=NREQ wraps back to i_ptr itself, so the last-served
        // requester is considered only when nobody else is pending.
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDX_W'((int'(i_ptr) + i) % NREQ);
            if (!found && i_pending[cand]) begin
                found          = 1'b1;
                o_onehot[cand] = 1'b1;
                o_idx          = cand;
            end
        end
        o_valid = found;
    end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter sharing one SDRAM access core among
// NREQ requesters. Latches the winner's command, holds it on the core until
// i_sdram_finished, returns read data with a one-cycle done pulse, then
// spends one GAP cycle so the core settles in its own IDLE before the next
// grant. All outputs are registered.
// Optional feature macro: SDRAM_ARB_TIMEOUT_EN (BUSY watchdog of TIMEOUT
// cycles; aborts with o_timeout + o_req_done). Undefined: o_timeout is 0.
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_req_read/i_req_write [NREQ], i_req_addr [NREQ*ADDR_W], i_req_wdata [NREQ*DATA_W]
//   o_req_rdata, o_req_done, o_grant, o_timeout
//   o_sdram_addr/read/write/writedata, i_sdram_readdata, i_sdram_finished
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NREQ-1:0]          i_req_read,
    input  logic [NREQ-1:0]          i_req_write,
    input  logic [NREQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NREQ*DATA_W-1:0]   i_req_wdata,
    output logic [DATA_W-1:0]        o_req_rdata,
    output logic [NREQ-1:0]          o_req_done,
    output logic [NREQ-1:0]          o_grant,
    output logic                     o_timeout,
    output logic [ADDR_W-1:0]        o_sdram_addr,
    output logic                     o_sdram_read,
    output logic                     o_sdram_write,
    output logic [DATA_W-1:0]        o_sdram_writedata,
    input  logic [DATA_W-1:0]        i_sdram_readdata,
    input  logic                     i_sdram_finished
);

    localparam int IDX_W = $clog2(NREQ);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;

    logic               pick_valid;
    logic [NREQ-1:0]    pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_write;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               to_q, to_d;
`else
    logic               unused_timeout_cfg;
    assign unused_timeout_cfg = |32'(TIMEOUT);
`endif

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_pending (i_req_read | i_req_write),
        .i_ptr     (ptr_q),
        .o_valid   (pick_valid),
        .o_onehot  (pick_onehot),
        .o_idx     (pick_idx)
    );

    // Winner's command fields; write wins over read from the same requester.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_onehot[k]) begin
                sel_addr  = i_req_addr[k*ADDR_W +: ADDR_W];
                sel_wdata = i_req_wdata[k*DATA_W +: DATA_W];
                sel_write = i_req_write[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        grant_d = grant_q;
        done_d  = '0;
        rd_d    = rd_q;
        wr_d    = wr_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    op_d    = sel_write ? OP_WRITE : OP_READ;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    ptr_d   = pick_idx;
                    grant_d = pick_onehot;
                    rd_d    = !sel_write;
                    wr_d    = sel_write;
                    state_d = BUSY;
`ifdef SDRAM_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (i_sdram_finished) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (op_q == OP_READ) rdata_d = i_sdram_readdata;
                    done_d  = grant_q;
                    state_d = GAP;
`ifdef SDRAM_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Last allowed BUSY cycle without finished: abort.
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    done_d  = grant_q;
                    to_d    = 1'b1;
                    state_d = GAP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            GAP: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            op_q    <= OP_READ;
            ptr_q   <= IDX_W'(NREQ - 1);
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            grant_q <= '0;
            done_q  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifdef SDRAM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign o_req_rdata       = rdata_q;
    assign o_req_done        = done_q;
    assign o_grant           = grant_q;
    assign o_sdram_addr      = addr_q;
    assign o_sdram_read      = rd_q;
    assign o_sdram_write     = wr_q;
    assign o_sdram_writedata = wdata_q;
`ifdef SDRAM_ARB_TIMEOUT_EN
    assign o_timeout         = to_q;
`else
    assign o_timeout         = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: self-checking bench for sdram_arbiter (NREQ=4, TIMEOUT=16).
// The reference model is a round-robin "last served" index plus the expected
// read-data register; the bench also plays the SDRAM core, raising finished
// after a chosen number of BUSY cycles.
module tb_sdram_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 23;
    localparam int DW   = 32;
    localparam int TO   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_read, req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]      req_rdata;
    logic [NREQ-1:0]    req_done, grant;
    logic               timeout;
    logic [AW-1:0]      sd_addr;
    logic               sd_read, sd_write;
    logic [DW-1:0]      sd_wdata, sd_rdata;
    logic               sd_finished;

    int          checks   = 0;
    int          failures = 0;
    int          m_ptr;
    logic [DW-1:0] m_rdata;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req_read        (req_read),
        .i_req_write       (req_write),
        .i_req_addr        (req_addr),
        .i_req_wdata       (req_wdata),
        .o_req_rdata       (req_rdata),
        .o_req_done        (req_done),
        .o_grant           (grant),
        .o_timeout         (timeout),
        .o_sdram_addr      (sd_addr),
        .o_sdram_read      (sd_read),
        .o_sdram_write     (sd_write),
        .o_sdram_writedata (sd_wdata),
        .i_sdram_readdata  (sd_rdata),
        .i_sdram_finished  (sd_finished)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_done"}, req_done, 0);
        check({tag, "_rdata"}, req_rdata, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_rdwr"}, {sd_read, sd_write}, 0);
        check({tag, "_addr"}, sd_addr, 0);
        check({tag, "_wdata"}, sd_wdata, 0);
    endtask

    task automatic rand_requests();
        req_read  = NREQ'($urandom);
        req_write = NREQ'($urandom & $urandom);
        for (int k = 0; k < NREQ; k++) begin
            req_addr[k*AW +: AW]  = AW'($urandom);
            req_wdata[k*DW +: DW] = $urandom;
        end
        if ((req_read | req_write) == '0) req_read[$urandom_range(0, NREQ-1)] = 1'b1;
    endtask

    // One full transaction, entered and left at a negedge with the DUT idle.
    // perturb: 0 none, 1 scramble all request inputs, 2 clear all requests.
    task automatic do_txn(input int lat, input logic [DW-1:0] rd, input int perturb,
                          input bit drop, input bit expect_to);
        logic [NREQ-1:0] pend;
        int              k;
        int              n;
        bit              is_wr;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ew;
        pend = req_read | req_write;
        k = -1;
        for (int i = 1; i <= NREQ; i++) begin
            int c = (m_ptr + i) % NREQ;
            if (k < 0 && pend[c]) k = c;
        end
        if (k < 0) begin
            $display("FAIL txn_setup no pending requester observed=0 expected=nonzero");
            $fatal(1, "bench stimulus error");
        end
        is_wr = req_write[k];
        ea    = req_addr[k*AW +: AW];
        ew    = req_wdata[k*DW +: DW];

        @(posedge clk); @(negedge clk);
        check("busy_grant", grant, 64'(1) << k);
        check("busy_read", sd_read, !is_wr);
        check("busy_write", sd_write, is_wr);
        check("busy_addr", sd_addr, ea);
        if (is_wr) check("busy_wdata", sd_wdata, ew);
        check("busy_done", req_done, 0);

        if (perturb == 1) rand_requests();
        else if (perturb == 2) begin
            req_read  = '0;
            req_write = '0;
        end

        n = expect_to ? TO - 1 : lat - 1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); @(negedge clk);
            check("hold_grant", grant, 64'(1) << k);
            check("hold_rdwr", {sd_read, sd_write}, {!is_wr, is_wr});
            check("hold_addr", sd_addr, ea);
            if (is_wr) check("hold_wdata", sd_wdata, ew);
            if (perturb == 1) rand_requests();
        end
        if (!expect_to) begin
            sd_finished = 1'b1;
            sd_rdata    = rd;
        end

        @(posedge clk); @(negedge clk);
        sd_finished = 1'b0;
        sd_rdata    = $urandom;
        if (!is_wr && !expect_to) m_rdata = rd;
        check("gap_rdwr", {sd_read, sd_write}, 0);
        check("gap_done", req_done, 64'(1) << k);
        check("gap_grant", grant, 64'(1) << k);
        check("gap_rdata", req_rdata, m_rdata);
        check("gap_timeout", timeout, expect_to);
        if (drop) begin
            req_read[k]  = 1'b0;
            req_write[k] = 1'b0;
        end

        @(posedge clk); @(negedge clk);
        check("idle_grant", grant, 0);
        check("idle_done", req_done, 0);
        check("idle_timeout", timeout, 0);
        check("idle_rdwr", {sd_read, sd_write}, 0);
        m_ptr = k;
    endtask

    initial begin
        rst         = 1'b1;
        req_read    = '0;
        req_write   = '0;
        req_addr    = '0;
        req_wdata   = '0;
        sd_rdata    = '0;
        sd_finished = 1'b0;
        m_ptr       = NREQ - 1;
        m_rdata     = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset_idle");

        // Single read from requester 1, core finishes after 5 BUSY cycles.
        req_read[1]        = 1'b1;
        req_addr[1*AW +: AW] = 23'h000123;
        do_txn(5, 32'hDEADBEEF, 0, 1'b1, 1'b0);

        // Requester 2 asserts write and read together; inputs toggled in BUSY.
        req_read[2]  = 1'b1;
        req_write[2] = 1'b1;
        req_addr[2*AW +: AW]  = 23'h7FFFFF;
        req_wdata[2*DW +: DW] = 32'h12345678;
        do_txn(4, 32'hCAFEF00D, 1, 1'b1, 1'b0);

        // Requester 0 drops its read in the middle of BUSY.
        req_read  = 4'b0001;
        req_write = '0;
        req_addr[0*AW +: AW] = 23'h00ABCD;
        do_txn(3, 32'h0BADCAFE, 2, 1'b0, 1'b0);

        // Fairness: all requesters hold reads continuously.
        req_read = '1;
        for (int t = 0; t < 2*NREQ; t++) do_txn($urandom_range(1, 4), $urandom, 0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 1) == 1 || (req_read | req_write) == '0) rand_requests();
            do_txn($urandom_range(1, 6), $urandom, $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Core never finishes: watchdog aborts, then the next requester is served.
        req_read  = '1;
        req_write = '0;
        do_txn(1, '0, 0, 1'b1, 1'b1);
        do_txn(2, 32'h55AA55AA, 0, 1'b1, 1'b0);
`endif

        // Reset in the middle of a BUSY read.
        req_read  = 4'b0100;
        req_write = '0;
        @(posedge clk); @(negedge clk);
        check("pre_rst_grant", grant, 4'b0100);
        check("pre_rst_read", sd_read, 1'b1);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); @(negedge clk);
        check_all_zero("held_rst");
        req_read = '1;
        rst      = 1'b0;
        m_ptr    = NREQ - 1;
        m_rdata  = '0;
        do_txn(2, 32'h13579BDF, 0, 1'b1, 1'b0);
        do_txn(1, 32'h2468ACE0, 0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
